cache_assoc: RTL and testbench



---
 rtl/cache_assoc.sv | 242 ++++++++++++++++++++++++
 tb/tb_cache_assoc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc.sv
// Set-associative write-back/write-allocate cache, 512-bit lines moved as four 128-bit beats, round-robin victims.
// Optional hit/miss statistics counters are built when CACHE_ASSOC_STATS_EN is defined.
module cache_assoc #(
  parameter int SETS           = 64,
  parameter int WAYS           = 2,
  parameter int CPU_WIDTH      = 32,
  parameter int WORD_ADDR_BITS = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic [WORD_ADDR_BITS-1:0] cpu_req_addr,
  input  logic [CPU_WIDTH-1:0]      cpu_req_data,
  input  logic [3:0]                cpu_req_write,
  output logic                      cpu_resp_valid,
  output logic [CPU_WIDTH-1:0]      cpu_resp_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [WORD_ADDR_BITS-3:0] mem_req_addr,
  output logic                      mem_req_rw,
  output logic                      mem_req_data_valid,
  input  logic                      mem_req_data_ready,
  output logic [127:0]              mem_req_data_bits,
  output logic [15:0]               mem_req_data_mask,
  input  logic                      mem_resp_valid,
  input  logic [127:0]              mem_resp_data,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int IB = $clog2(SETS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TB = WORD_ADDR_BITS - IB - 4;

  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, WB, REFILL, RESP} state_t;

  state_t               state;
  logic [IB-1:0]        init_cnt;
  logic [TB-1:0]        tag_q;
  logic [IB-1:0]        idx_q;
  logic [3:0]           word_q;
  logic [CPU_WIDTH-1:0] wdata_q;
  logic [3:0]           wmask_q;
  logic [WW-1:0]        victim_q;
  logic [1:0]           beat_q;
  logic [1:0]           rbeat_q;
  logic                 cmd_seen;
  logic                 dat_seen;

  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WW-1:0]        ptr_q   [SETS];
  logic [TB-1:0]        tag_arr [SETS][WAYS];
  logic [CPU_WIDTH-1:0] data_q  [WAYS][SETS][16];

  logic          hit;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] vic_way;
  logic          cmd_done;
  logic          dat_done;

  assign mem_req_data_mask = 16'hFFFF;
  assign cmd_done = cmd_seen | (mem_req_valid & mem_req_ready);
  assign dat_done = dat_seen | (mem_req_data_valid & mem_req_data_ready);

  // Victim is the lowest invalid way; only when the set is full does the pointer decide.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = ptr_q[idx_q];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx_q][w] && tag_arr[idx_q][w] == tag_q) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_q][w]) vic_way = WW'(w);
    end
  end

  function automatic logic [CPU_WIDTH-1:0] merge(input logic [CPU_WIDTH-1:0] old_w,
                                                 input logic [CPU_WIDTH-1:0] new_w,
                                                 input logic [3:0] m);
    merge = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) merge[b*8 +: 8] = new_w[b*8 +: 8];
    end
  endfunction

  function automatic logic [127:0] line_beat(input logic [WW-1:0] way, input logic [1:0] b);
    line_beat = '0;
    for (int k = 0; k < 4; k++) begin
      line_beat[k*CPU_WIDTH +: CPU_WIDTH] = data_q[way][idx_q][{b, 2'(k)}];
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= INIT;
      init_cnt           <= '0;
      cpu_req_ready      <= 1'b0;
      cpu_resp_valid     <= 1'b0;
      mem_req_valid      <= 1'b0;
      mem_req_data_valid <= 1'b0;
      mem_req_rw         <= 1'b0;
      beat_q             <= '0;
      rbeat_q            <= '0;
      cmd_seen           <= 1'b0;
      dat_seen           <= 1'b0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        INIT: begin
          valid_q[init_cnt] <= '0;
          dirty_q[init_cnt] <= '0;
          ptr_q[init_cnt]   <= '0;
          init_cnt          <= init_cnt + IB'(1);
          if (init_cnt == IB'(SETS - 1)) begin
            state         <= IDLE;
            cpu_req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (cpu_req_valid) begin
            tag_q         <= cpu_req_addr[WORD_ADDR_BITS-1 -: TB];
            idx_q         <= cpu_req_addr[4 +: IB];
            word_q        <= cpu_req_addr[3:0];
            wdata_q       <= cpu_req_data;
            wmask_q       <= cpu_req_write;
            cpu_req_ready <= 1'b0;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_resp_data <= data_q[hit_way][idx_q][word_q];
            if (|wmask_q) begin
              data_q[hit_way][idx_q][word_q] <= merge(data_q[hit_way][idx_q][word_q], wdata_q, wmask_q);
              dirty_q[idx_q][hit_way]        <= 1'b1;
            end
            cpu_resp_valid <= 1'b1;
            cpu_req_ready  <= 1'b1;
            state          <= IDLE;
          end else begin
            victim_q      <= vic_way;
            beat_q        <= '0;
            rbeat_q       <= '0;
            cmd_seen      <= 1'b0;
            dat_seen      <= 1'b0;
            mem_req_valid <= 1'b1;
            if (valid_q[idx_q][vic_way] && dirty_q[idx_q][vic_way]) begin
              state              <= WB;
              mem_req_rw         <= 1'b1;
              mem_req_data_valid <= 1'b1;
              mem_req_addr       <= {tag_arr[idx_q][vic_way], idx_q, 2'd0};
              mem_req_data_bits  <= line_beat(vic_way, 2'd0);
            end else begin
              state        <= REFILL;
              mem_req_rw   <= 1'b0;
              mem_req_addr <= {tag_q, idx_q, 2'd0};
            end
          end
        end
        WB: begin
          // Address and data channels complete independently; a beat retires once both have.
          if (mem_req_ready) mem_req_valid <= 1'b0;
          if (mem_req_data_ready) mem_req_data_valid <= 1'b0;
          cmd_seen <= cmd_done;
          dat_seen <= dat_done;
          if (cmd_done && dat_done) begin
            cmd_seen      <= 1'b0;
            dat_seen      <= 1'b0;
            mem_req_valid <= 1'b1;
            if (beat_q == 2'd3) begin
              state        <= REFILL;
              beat_q       <= '0;
              mem_req_rw   <= 1'b0;
              mem_req_addr <= {tag_q, idx_q, 2'd0};
            end else begin
              beat_q             <= beat_q + 2'd1;
              mem_req_data_valid <= 1'b1;
              mem_req_addr[1:0]  <= beat_q + 2'd1;
              mem_req_data_bits  <= line_beat(victim_q, beat_q + 2'd1);
            end
          end
        end
        REFILL: begin
          if (mem_req_valid && mem_req_ready) begin
            if (beat_q == 2'd3) begin
              mem_req_valid <= 1'b0;
            end else begin
              beat_q            <= beat_q + 2'd1;
              mem_req_addr[1:0] <= beat_q + 2'd1;
            end
          end
          if (mem_resp_valid) begin
            for (int k = 0; k < 4; k++) begin
              data_q[victim_q][idx_q][{rbeat_q, 2'(k)}] <= mem_resp_data[k*CPU_WIDTH +: CPU_WIDTH];
            end
            rbeat_q <= rbeat_q + 2'd1;
            if (rbeat_q == 2'd3) begin
              valid_q[idx_q][victim_q] <= 1'b1;
              dirty_q[idx_q][victim_q] <= 1'b0;
              tag_arr[idx_q][victim_q] <= tag_q;
              state                    <= RESP;
            end
          end
        end
        RESP: begin
          cpu_resp_data <= data_q[victim_q][idx_q][word_q];
          if (|wmask_q) begin
            data_q[victim_q][idx_q][word_q] <= merge(data_q[victim_q][idx_q][word_q], wdata_q, wmask_q);
            dirty_q[idx_q][victim_q]        <= 1'b1;
          end
          if (WAYS > 1) ptr_q[idx_q] <= victim_q + WW'(1);
          cpu_resp_valid <= 1'b1;
          cpu_req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef CACHE_ASSOC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_count <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc: fills, hits, dirty evictions, write-data stall, reset mid-refill.
module tb_cache_assoc;

`ifdef CACHE_ASSOC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic [29:0]  cpu_req_addr;
  logic [31:0]  cpu_req_data;
  logic [3:0]   cpu_req_write;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  cache_assoc dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_write(cpu_req_write),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: unwritten beats read back as 0xC0000000 | word address.
  logic [127:0] mem [logic [27:0]];
  logic [27:0]  rd_q[$];
  logic [27:0]  wr_aq[$];
  logic [127:0] wr_dq[$];
  logic [27:0]  rd_log[$];
  logic [27:0]  wr_log_a[$];
  logic [127:0] wr_log_d[$];
  logic [27:0]  pa;
  logic [127:0] pd;
  logic [27:0]  snap_addr;
  logic [127:0] snap_data;
  bit           stall_seen = 1'b0;
  int           stall_cycles = 0;
  int           dat_stall_arm = 0;

  function automatic logic [127:0] mem_rd(input logic [27:0] ba);
    logic [127:0] v;
    if (mem.exists(ba)) return mem[ba];
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = 32'hC000_0000 | 32'({ba, 2'(k)});
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      rd_q.delete();
      wr_aq.delete();
      wr_dq.delete();
      mem_resp_valid = 1'b0;
      stall_seen     = 1'b0;
    end else begin
      mem_resp_valid = 1'b0;
      if (rd_q.size() > 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_rd(rd_q.pop_front());
      end
      mem_req_ready      = 1'b1;
      mem_req_data_ready = 1'b1;
      if (mem_req_data_valid && dat_stall_arm > 0) begin
        mem_req_data_ready = 1'b0;
        dat_stall_arm--;
      end
      if (mem_req_data_valid && !mem_req_data_ready) begin
        if (stall_seen) begin
          check_eq("wb_addr_stable", mem_req_addr, snap_addr);
          check_eq("wb_data_stable", mem_req_data_bits, snap_data);
        end
        snap_addr  = mem_req_addr;
        snap_data  = mem_req_data_bits;
        stall_seen = 1'b1;
        stall_cycles++;
      end else begin
        stall_seen = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_rw) wr_aq.push_back(mem_req_addr);
        else begin
          rd_q.push_back(mem_req_addr);
          rd_log.push_back(mem_req_addr);
        end
      end
      if (mem_req_data_valid && mem_req_data_ready) wr_dq.push_back(mem_req_data_bits);
      while (wr_aq.size() > 0 && wr_dq.size() > 0) begin
        pa = wr_aq.pop_front();
        pd = wr_dq.pop_front();
        mem[pa] = pd;
        wr_log_a.push_back(pa);
        wr_log_d.push_back(pd);
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log_a.delete();
    wr_log_d.delete();
  endtask

  task automatic wait_ready(input string tag);
    int edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!cpu_req_ready && edges < 500);
    check_eq(tag, edges, 64);
  endtask

  task automatic cpu_access(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                            output logic [31:0] rd, output int lat);
    int n = 0;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    cpu_req_data  = d;
    cpu_req_write = m;
    while (!cpu_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_write = 4'b0;
    lat = 1;
    while (!cpu_resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (n >= 200 || lat >= 400) check_eq("cpu_timeout", 1'b1, 1'b0);
    rd = cpu_resp_data;
  endtask

  logic [31:0] rd;
  int          lat;
  int          n;

  initial begin
    reset = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_data  = '0;
    cpu_req_write = '0;
    mem_req_ready = 1'b1;
    mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem[28'h40] = {32'hC000_0103, 32'hC000_0102, 32'hC000_0101, 32'hDEAD_BEEF};
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cpu_req_ready, 1'b0);
    check_eq("rst_resp_valid", cpu_resp_valid, 1'b0);
    check_eq("rst_mem_valid", mem_req_valid, 1'b0);
    check_eq("rst_mem_data_valid", mem_req_data_valid, 1'b0);
    check_eq("rst_mem_rw", mem_req_rw, 1'b0);
    check_eq("rst_hits", hit_count, 0);
    check_eq("rst_misses", miss_count, 0);
    reset = 1'b0;
    wait_ready("init_len");
    check_eq("mask_const", mem_req_data_mask, 16'hFFFF);

    // Cold read, then hit, then partial write and read-back.
    clear_logs();
    cpu_access(30'h100, 32'h0, 4'b0, rd, lat);
    check_eq("cold_data", rd, 32'hDEADBEEF);
    check_eq("cold_lat", lat, 8);
    check_eq("cold_rd_beats", rd_log.size(), 4);
    check_eq("cold_rd_first", rd_log[0], 28'h40);
    check_eq("cold_rd_last", rd_log[3], 28'h43);
    check_eq("cold_wr_beats", wr_log_a.size(), 0);
    clear_logs();
    cpu_access(30'h100, 32'h0, 4'b0, rd, lat);
    check_eq("hit_data", rd, 32'hDEADBEEF);
    check_eq("hit_lat", lat, 2);
    check_eq("hit_rd_beats", rd_log.size(), 0);
    cpu_access(30'h100, 32'h12345678, 4'b0011, rd, lat);
    check_eq("wr_hit_lat", lat, 2);
    cpu_access(30'h100, 32'h0, 4'b0, rd, lat);
    check_eq("merge_data", rd, 32'hDEAD5678);
    check_eq("merge_rd_beats", rd_log.size(), 0);
    check_eq("stat_hits", hit_count, STATS ? 3 : 0);
    check_eq("stat_misses", miss_count, STATS ? 1 : 0);

    // Set 0: A, B fill both ways; dirty A; C evicts A with write-back; A then evicts clean B.
    cpu_access(30'h400, 32'h0, 4'b0, rd, lat);
    cpu_access(30'h800, 32'h0, 4'b0, rd, lat);
    cpu_access(30'h400, 32'hA5A5A5A5, 4'b1111, rd, lat);
    clear_logs();
    cpu_access(30'hC00, 32'h0, 4'b0, rd, lat);
    check_eq("evict_c_data", rd, 32'hC0000C00);
    check_eq("evict_wr_beats", wr_log_a.size(), 4);
    for (int k = 0; k < 4; k++) check_eq("evict_wr_addr", wr_log_a[k], 28'h100 + 28'(k));
    check_eq("evict_wr_data0", wr_log_d[0],
             {32'hC0000403, 32'hC0000402, 32'hC0000401, 32'hA5A5A5A5});
    check_eq("evict_rd_first", rd_log[0], 28'h300);
    clear_logs();
    cpu_access(30'h400, 32'h0, 4'b0, rd, lat);
    check_eq("refetch_a_data", rd, 32'hA5A5A5A5);
    check_eq("refetch_a_wr", wr_log_a.size(), 0);
    check_eq("refetch_a_rd", rd_log.size(), 4);
    clear_logs();
    cpu_access(30'h800, 32'h0, 4'b0, rd, lat);
    check_eq("b_evicted_rd", rd_log.size(), 4);
    check_eq("b_data", rd, 32'hC0000800);

    // Set 2: dirty eviction with write-data ready held low for 5 cycles.
    cpu_access(30'h420, 32'h0, 4'b0, rd, lat);
    cpu_access(30'h820, 32'h0, 4'b0, rd, lat);
    cpu_access(30'h420, 32'h11112222, 4'b1111, rd, lat);
    clear_logs();
    stall_cycles  = 0;
    dat_stall_arm = 5;
    cpu_access(30'hC20, 32'h0, 4'b0, rd, lat);
    check_eq("stall_cycles", stall_cycles, 5);
    check_eq("stall_wr_beats", wr_log_a.size(), 4);
    for (int k = 0; k < 4; k++) check_eq("stall_wr_addr", wr_log_a[k], 28'h108 + 28'(k));
    check_eq("stall_wr_data0", wr_log_d[0],
             {32'hC0000423, 32'hC0000422, 32'hC0000421, 32'h11112222});
    check_eq("stall_f_data", rd, 32'hC0000C20);

    // Reset during refill beat 2 of a cold read.
    clear_logs();
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 30'h1040;
    cpu_req_write = 4'b0;
    n = 0;
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (!(mem_req_valid && !mem_req_rw && mem_req_addr[1:0] == 2'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat2_seen", n < 100, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_mem_valid", mem_req_valid, 1'b0);
    check_eq("abort_ready", cpu_req_ready, 1'b0);
    check_eq("abort_resp", cpu_resp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready("init_len_2");
    clear_logs();
    cpu_access(30'h1040, 32'h0, 4'b0, rd, lat);
    check_eq("post_rst_rd", rd_log.size(), 4);
    check_eq("post_rst_data", rd, 32'hC0001040);
    clear_logs();
    cpu_access(30'h100, 32'h0, 4'b0, rd, lat);
    check_eq("post_rst_miss_100", rd_log.size(), 4);
    check_eq("dirty_discarded", rd, 32'hDEADBEEF);
    check_eq("post_rst_wr", wr_log_a.size(), 0);
    check_eq("post_rst_hits", hit_count, 0);
    check_eq("post_rst_misses", miss_count, STATS ? 2 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got expired expected completion");
    $fatal(1);
  end

endmodule
